wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatter for the pipelined MIPS core.
- Captures the MEM-stage result, extracts and extends load data, and arbitrates ordinary register writes against link writes.
- Drives the register-file write port: RegWrite, wa, wd, Link, LinkAddr and LinkData.
- Also presents the value being retired to the forwarding unit.

Parameters:
DW, 32, datapath width (load extraction requires 32)
AW, 5, register address width

Ports:
clk  in  1  core clock; WB register updates on posedge
rst_n  in  1  asynchronous, active-low reset
mem_valid_i  in  1  MEM stage holds a real instruction
mem_regwrite_i  in  1  instruction writes rt/rd
mem_wa_i  in  AW  destination register
mem_alu_i  in  DW  ALU result / effective address
mem_rdata_i  in  DW  raw aligned word from data memory
mem_ld_type_i  in  3  000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU
mem_link_i  in  2  00 none, 01 JAL ($31), 10 JALR (mem_link_addr_i)
mem_link_addr_i  in  AW  JALR destination
mem_pc4_i  in  DW  PC+4 of the instruction
stall_i  in  1  hold the WB register
flush_i  in  1  load a bubble
rf_regwrite_o  out  1  to RF RegWrite
rf_wa_o  out  AW  to RF wa_i
rf_wd_o  out  DW  to RF wd_i
rf_link_o  out  2  to RF Link
rf_link_addr_o  out  AW  to RF LinkAddr
rf_link_data_o  out  DW  to RF LinkData
fwd_valid_o  out  1  WB writes a nonzero register this cycle
fwd_wa_o  out  AW  register being written (link or normal)
fwd_data_o  out  DW  value being written
misalign_o  out  1  retiring load was misaligned (one cycle per retirement)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All WB state clears: valid=0.
  - All outputs are 0, including rf_link_o=00.
- Register update priority at posedge clk: flush_i, then stall_i, then normal load.
  - flush_i: valid<=0.
  - stall_i: hold all state.
  - Otherwise: capture all mem_* inputs.
  - flush_i during stall_i: flush wins.
- Latency:
  - Fields captured at posedge N appear on the outputs during cycle N.
  - All rf_* and fwd_* outputs are combinational from the WB register.
  - The RF samples them at the following negedge (half-cycle write-before-read).
- Load formatting uses alu[1:0] and big-endian lanes:
  - Byte 0 = bits 31:24, byte 3 = bits 7:0.
  - Halfword 0 = bits 31:16, halfword 2 = bits 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through; ld_type 000 passes the ALU result.
- Misalignment:
  - LW with alu[1:0]!=0, or LH/LHU with alu[0]=1.
  - Suppresses the write (rf_regwrite_o=0) and asserts misalign_o while valid.
  - Held (still asserted) while stalled.
- Write arbitration, valid=1 only:
  - link!=00: rf_regwrite_o=0; rf_link_o=link.
    - Link 01 always targets $31.
    - Link 10 with link_addr=0: rf_link_o forced to 00.
  - link==00: rf_regwrite_o = regwrite & ~misalign & (wa!=0).
  - ld_type!=000 together with link!=00 is illegal; link takes precedence.
  - Undefined ld_type 110/111 behaves as 000.
- Data routing:
  - rf_link_data_o = pc4.
  - rf_link_addr_o = link_addr.
  - rf_wd_o = formatted data.
- Forwarding outputs:
  - fwd_valid_o = 1 when an effective register write (normal or link) targets a nonzero register.
  - fwd_wa_o = 31 for link 01, link_addr for link 10, wa otherwise.
  - fwd_data_o = pc4 for any link, formatted data otherwise.
  - When fwd_valid_o=0: fwd_wa_o=0 and fwd_data_o=0.
- Stall holding: held outputs repeat the identical RF write each cycle (idempotent; allowed).
- valid=0: every rf_* output is 0, fwd_valid_o=0, misalign_o=0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt_o [31:0], reset to 0.
  - Increments by 1 on each posedge where valid=1 and stall_i=0 (instruction leaves WB); wraps at 2^32.
  - Misaligned and bubble cycles do not count as retirements; misaligned retirements are not counted.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset release, then ADD: wa=8, alu=0x1234 -> next cycle rf_regwrite_o=1, rf_wa_o=8, rf_wd_o=0x00001234, fwd_valid_o=1.
- LB, alu[1:0]=1, rdata=0x11F2_3344 -> rf_wd_o=0xFFFFFFF2. Same with LBU -> 0x000000F2. LH, alu[1:0]=2 -> 0x00003344.
- LW, alu=0x1002 -> rf_regwrite_o=0, misalign_o=1 for one cycle. LHU, alu=0x1001 -> same.
- JAL with pc4=0x3008 and regwrite=1, wa=31 -> rf_link_o=01, rf_regwrite_o=0, fwd_wa_o=31, fwd_data_o=0x3008. JALR with link_addr=0 -> rf_link_o=00, fwd_valid_o=0.
- Stall 3 cycles mid-stream -> outputs held unchanged. Assert flush_i together with stall_i -> next cycle valid=0, all rf_* outputs 0. Pull rst_n low mid-stall -> outputs 0 immediately, without a clock edge.
- WB_RETIRE_CNT_EN defined: 5 instructions, 1 misaligned, 2 stall cycles, 1 flush bubble -> retire_cnt_o=4.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- MEM/WB pipeline register and writeback formatter.
//
// Captures the MEM-stage result, extracts and extends big-endian load data,
// and arbitrates ordinary register writes against link (JAL/JALR) writes.
// It then drives the register-file write port and the forwarding unit.
//
// Ports:
//   clk, rst_n            core clock; asynchronous active-low reset
//   mem_valid_i           MEM stage holds a real instruction
//   mem_regwrite_i        instruction writes rt/rd
//   mem_wa_i              destination register
//   mem_alu_i             ALU result / effective address
//   mem_rdata_i           raw aligned word from data memory
//   mem_ld_type_i         000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU
//   mem_link_i            00 none, 01 JAL ($31), 10 JALR (mem_link_addr_i)
//   mem_link_addr_i       JALR destination
//   mem_pc4_i             PC+4 of the instruction
//   stall_i / flush_i     hold the WB register / load a bubble (flush wins)
//   rf_*_o                register-file write port (RegWrite, wa, wd, Link,
//                         LinkAddr, LinkData)
//   fwd_valid_o/wa_o/data_o  value being retired, for forwarding
//   misalign_o            retiring load was misaligned
//   retire_cnt_o          retired-instruction count (WB_RETIRE_CNT_EN only)
//
// Optional feature: define WB_RETIRE_CNT_EN to add the 32-bit retire counter.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid_i,
  input  logic          mem_regwrite_i,
  input  logic [AW-1:0] mem_wa_i,
  input  logic [DW-1:0] mem_alu_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic [2:0]    mem_ld_type_i,
  input  logic [1:0]    mem_link_i,
  input  logic [AW-1:0] mem_link_addr_i,
  input  logic [DW-1:0] mem_pc4_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          rf_regwrite_o,
  output logic [AW-1:0] rf_wa_o,
  output logic [DW-1:0] rf_wd_o,
  output logic [1:0]    rf_link_o,
  output logic [AW-1:0] rf_link_addr_o,
  output logic [DW-1:0] rf_link_data_o,
  output logic          fwd_valid_o,
  output logic [AW-1:0] fwd_wa_o,
  output logic [DW-1:0] fwd_data_o,
  output logic          misalign_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_cnt_o
`endif
);

  localparam logic [AW-1:0] RA_REG = AW'(31);

  logic          valid_reg;
  logic          regwrite_reg;
  logic [AW-1:0] wa_reg;
  logic [DW-1:0] alu_reg;
  logic [DW-1:0] rdata_reg;
  logic [2:0]    ld_type_reg;
  logic [1:0]    link_reg;
  logic [AW-1:0] link_addr_reg;
  logic [DW-1:0] pc4_reg;

  // WB register: flush beats stall beats capture. A flush only drops valid;
  // the stale payload is masked by valid on every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      wa_reg        <= '0;
      alu_reg       <= '0;
      rdata_reg     <= '0;
      ld_type_reg   <= 3'b000;
      link_reg      <= 2'b00;
      link_addr_reg <= '0;
      pc4_reg       <= '0;
    end else if (flush_i) begin
      valid_reg <= 1'b0;
    end else if (!stall_i) begin
      valid_reg     <= mem_valid_i;
      regwrite_reg  <= mem_regwrite_i;
      wa_reg        <= mem_wa_i;
      alu_reg       <= mem_alu_i;
      rdata_reg     <= mem_rdata_i;
      ld_type_reg   <= mem_ld_type_i;
      link_reg      <= mem_link_i;
      link_addr_reg <= mem_link_addr_i;
      pc4_reg       <= mem_pc4_i;
    end
  end

  // Load extraction: big-endian lanes, byte 0 lives in bits 31:24.
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;
  logic          ld_misalign;

  always_comb begin
    ld_byte     = 8'h00;
    ld_half     = alu_reg[1] ? rdata_reg[15:0] : rdata_reg[31:16];
    ld_data     = alu_reg;
    ld_misalign = 1'b0;
    case (alu_reg[1:0])
      2'd0:    ld_byte = rdata_reg[31:24];
      2'd1:    ld_byte = rdata_reg[23:16];
      2'd2:    ld_byte = rdata_reg[15:8];
      default: ld_byte = rdata_reg[7:0];
    endcase
    case (ld_type_reg)
      3'b001: begin
        ld_data     = rdata_reg;
        ld_misalign = (alu_reg[1:0] != 2'b00);
      end
      3'b010: begin
        ld_data     = {{(DW-16){ld_half[15]}}, ld_half};
        ld_misalign = alu_reg[0];
      end
      3'b011: begin
        ld_data     = {{(DW-16){1'b0}}, ld_half};
        ld_misalign = alu_reg[0];
      end
      3'b100:  ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
      3'b101:  ld_data = {{(DW-8){1'b0}}, ld_byte};
      default: ld_data = alu_reg;  // 000 and undefined 110/111
    endcase
  end

  // Write arbitration. Any nonzero link code suppresses the normal write,
  // even when a load type is also present. JALR to $0 (and the unused 11
  // code) becomes no write at all.
  logic is_link;
  logic link_jal;
  logic link_jalr;
  logic normal_we;

  always_comb begin
    is_link   = (link_reg != 2'b00);
    link_jal  = (link_reg == 2'b01);
    link_jalr = (link_reg == 2'b10) && (link_addr_reg != '0);
    normal_we = regwrite_reg && !ld_misalign && (wa_reg != '0) && !is_link;

    rf_regwrite_o  = valid_reg && normal_we;
    rf_link_o      = 2'b00;
    rf_wa_o        = '0;
    rf_wd_o        = '0;
    rf_link_addr_o = '0;
    rf_link_data_o = '0;
    misalign_o     = valid_reg && ld_misalign && !is_link;
    fwd_valid_o    = valid_reg && (normal_we || link_jal || link_jalr);
    fwd_wa_o       = '0;
    fwd_data_o     = '0;

    if (valid_reg) begin
      if (link_jal)
        rf_link_o = 2'b01;
      else if (link_jalr)
        rf_link_o = 2'b10;
      rf_wa_o        = wa_reg;
      rf_wd_o        = ld_data;
      rf_link_addr_o = link_addr_reg;
      rf_link_data_o = pc4_reg;
    end

    if (fwd_valid_o) begin
      if (link_jal) begin
        fwd_wa_o   = RA_REG;
        fwd_data_o = pc4_reg;
      end else if (link_jalr) begin
        fwd_wa_o   = link_addr_reg;
        fwd_data_o = pc4_reg;
      end else begin
        fwd_wa_o   = wa_reg;
        fwd_data_o = ld_data;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires when it leaves WB unstalled; misaligned loads
  // and bubbles are not retirements.
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt_reg <= 32'd0;
    else if (valid_reg && !stall_i && !misalign_o)
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
  end

  assign retire_cnt_o = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid_i;
  logic          mem_regwrite_i;
  logic [AW-1:0] mem_wa_i;
  logic [DW-1:0] mem_alu_i;
  logic [DW-1:0] mem_rdata_i;
  logic [2:0]    mem_ld_type_i;
  logic [1:0]    mem_link_i;
  logic [AW-1:0] mem_link_addr_i;
  logic [DW-1:0] mem_pc4_i;
  logic          stall_i;
  logic          flush_i;
  logic          rf_regwrite_o;
  logic [AW-1:0] rf_wa_o;
  logic [DW-1:0] rf_wd_o;
  logic [1:0]    rf_link_o;
  logic [AW-1:0] rf_link_addr_o;
  logic [DW-1:0] rf_link_data_o;
  logic          fwd_valid_o;
  logic [AW-1:0] fwd_wa_o;
  logic [DW-1:0] fwd_data_o;
  logic          misalign_o;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]   retire_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_stage #(.DW(DW), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_valid_i     (mem_valid_i),
    .mem_regwrite_i  (mem_regwrite_i),
    .mem_wa_i        (mem_wa_i),
    .mem_alu_i       (mem_alu_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_ld_type_i   (mem_ld_type_i),
    .mem_link_i      (mem_link_i),
    .mem_link_addr_i (mem_link_addr_i),
    .mem_pc4_i       (mem_pc4_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .rf_regwrite_o   (rf_regwrite_o),
    .rf_wa_o         (rf_wa_o),
    .rf_wd_o         (rf_wd_o),
    .rf_link_o       (rf_link_o),
    .rf_link_addr_o  (rf_link_addr_o),
    .rf_link_data_o  (rf_link_data_o),
    .fwd_valid_o     (fwd_valid_o),
    .fwd_wa_o        (fwd_wa_o),
    .fwd_data_o      (fwd_data_o),
    .misalign_o      (misalign_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o    (retire_cnt_o)
`endif
  );

  // Advance one clock; outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic [AW-1:0] wa,
                           input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                           input logic [2:0] ld, input logic [1:0] link,
                           input logic [AW-1:0] laddr, input logic [DW-1:0] pc4);
    mem_valid_i     = v;
    mem_regwrite_i  = rw;
    mem_wa_i        = wa;
    mem_alu_i       = alu;
    mem_rdata_i     = rdata;
    mem_ld_type_i   = ld;
    mem_link_i      = link;
    mem_link_addr_i = laddr;
    mem_pc4_i       = pc4;
    $display("txn v=%0b rw=%0b wa=%0d alu=%h rdata=%h ld=%b link=%b laddr=%0d pc4=%h stall=%0b flush=%0b",
             v, rw, wa, alu, rdata, ld, link, laddr, pc4, stall_i, flush_i);
  endtask

  task automatic set_bubble();
    set_instr(1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00, '0, '0);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_bubble();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_instr(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0, 3'b000, 2'b01, 5'd3, 32'h44);
    tick();
    total++; if (rf_regwrite_o !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", rf_regwrite_o); else passed++;
    total++; if (rf_link_o !== 2'b00) $display("FAIL reset_link: got %b want 00", rf_link_o); else passed++;
    total++; if (rf_wd_o !== 32'h0) $display("FAIL reset_wd: got %h want 0", rf_wd_o); else passed++;
    total++; if (rf_link_data_o !== 32'h0) $display("FAIL reset_link_data: got %h want 0", rf_link_data_o); else passed++;
    total++; if (fwd_valid_o !== 1'b0 || fwd_data_o !== 32'h0) $display("FAIL reset_fwd: got %b/%h want 0/0", fwd_valid_o, fwd_data_o); else passed++;
    total++; if (misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_o); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    set_bubble();
  endtask

  task automatic test_add();
    set_instr(1'b1, 1'b1, 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 3'b000, 2'b00, '0, 32'h100);
    tick();
    total++; if (rf_regwrite_o !== 1'b1) $display("FAIL add_regwrite: got %b want 1", rf_regwrite_o); else passed++;
    total++; if (rf_wa_o !== 5'd8) $display("FAIL add_wa: got %0d want 8", rf_wa_o); else passed++;
    total++; if (rf_wd_o !== 32'h0000_1234) $display("FAIL add_wd: got %h want 00001234", rf_wd_o); else passed++;
    total++; if (fwd_valid_o !== 1'b1 || fwd_wa_o !== 5'd8 || fwd_data_o !== 32'h1234)
      $display("FAIL add_fwd: got %b/%0d/%h want 1/8/00001234", fwd_valid_o, fwd_wa_o, fwd_data_o); else passed++;
    // write to $0 is dropped and not forwarded
    set_instr(1'b1, 1'b1, 5'd0, 32'h0000_0077, 32'h0, 3'b000, 2'b00, '0, 32'h104);
    tick();
    total++; if (rf_regwrite_o !== 1'b0 || fwd_valid_o !== 1'b0)
      $display("FAIL add_r0: got rw=%b fv=%b want 0/0", rf_regwrite_o, fwd_valid_o); else passed++;
  endtask

  task automatic test_loads();
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1001, 32'h11F2_3344, 3'b100, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'hFFFF_FFF2) $display("FAIL lb_sext: got %h want FFFFFFF2", rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1001, 32'h11F2_3344, 3'b101, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'h0000_00F2) $display("FAIL lbu_zext: got %h want 000000F2", rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1002, 32'h11F2_3344, 3'b010, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'h0000_3344 || rf_regwrite_o !== 1'b1)
      $display("FAIL lh_lane2: got %h rw=%b want 00003344 rw=1", rf_wd_o, rf_regwrite_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1000, 32'h8001_5566, 3'b010, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'hFFFF_8001) $display("FAIL lh_sext: got %h want FFFF8001", rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1000, 32'h8001_5566, 3'b011, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'h0000_8001) $display("FAIL lhu_zext: got %h want 00008001", rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'h11F2_3384, 3'b100, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'hFFFF_FF84) $display("FAIL lb_lane3: got %h want FFFFFF84", rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd6, 32'h0000_1004, 32'hCAFE_F00D, 3'b001, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'hCAFE_F00D || fwd_data_o !== 32'hCAFE_F00D)
      $display("FAIL lw_word: got %h/%h want CAFEF00D", rf_wd_o, fwd_data_o); else passed++;
    // undefined load type behaves as no load
    set_instr(1'b1, 1'b1, 5'd6, 32'h0000_ABCD, 32'h1111_2222, 3'b111, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_wd_o !== 32'h0000_ABCD) $display("FAIL ld_undef: got %h want 0000ABCD", rf_wd_o); else passed++;
  endtask

  task automatic test_misalign();
    set_instr(1'b1, 1'b1, 5'd9, 32'h0000_1002, 32'h1234_5678, 3'b001, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_regwrite_o !== 1'b0 || misalign_o !== 1'b1 || fwd_valid_o !== 1'b0)
      $display("FAIL lw_misalign: got rw=%b mis=%b fv=%b want 0/1/0", rf_regwrite_o, misalign_o, fwd_valid_o); else passed++;
    set_bubble();
    tick();
    total++; if (misalign_o !== 1'b0) $display("FAIL misalign_one_cycle: got %b want 0", misalign_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd9, 32'h0000_1001, 32'h1234_5678, 3'b011, 2'b00, '0, 32'h0);
    tick();
    total++; if (rf_regwrite_o !== 1'b0 || misalign_o !== 1'b1)
      $display("FAIL lhu_misalign: got rw=%b mis=%b want 0/1", rf_regwrite_o, misalign_o); else passed++;
  endtask

  task automatic test_link();
    set_instr(1'b1, 1'b1, 5'd31, 32'h0000_0040, 32'h0, 3'b000, 2'b01, 5'd0, 32'h0000_3008);
    tick();
    total++; if (rf_link_o !== 2'b01 || rf_regwrite_o !== 1'b0)
      $display("FAIL jal_port: got link=%b rw=%b want 01/0", rf_link_o, rf_regwrite_o); else passed++;
    total++; if (rf_link_data_o !== 32'h3008) $display("FAIL jal_link_data: got %h want 00003008", rf_link_data_o); else passed++;
    total++; if (fwd_valid_o !== 1'b1 || fwd_wa_o !== 5'd31 || fwd_data_o !== 32'h3008)
      $display("FAIL jal_fwd: got %b/%0d/%h want 1/31/00003008", fwd_valid_o, fwd_wa_o, fwd_data_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd12, 32'h0000_0040, 32'h0, 3'b000, 2'b10, 5'd0, 32'h0000_300C);
    tick();
    total++; if (rf_link_o !== 2'b00 || rf_regwrite_o !== 1'b0)
      $display("FAIL jalr_r0_port: got link=%b rw=%b want 00/0", rf_link_o, rf_regwrite_o); else passed++;
    total++; if (fwd_valid_o !== 1'b0 || fwd_wa_o !== 5'd0 || fwd_data_o !== 32'h0)
      $display("FAIL jalr_r0_fwd: got %b/%0d/%h want 0/0/0", fwd_valid_o, fwd_wa_o, fwd_data_o); else passed++;
    // JALR with a real target, plus an illegal load type that link overrides
    set_instr(1'b1, 1'b1, 5'd12, 32'h0000_0041, 32'h0, 3'b001, 2'b10, 5'd5, 32'h0000_3010);
    tick();
    total++; if (rf_link_o !== 2'b10 || rf_link_addr_o !== 5'd5 || rf_regwrite_o !== 1'b0 || misalign_o !== 1'b0)
      $display("FAIL jalr_port: got link=%b la=%0d rw=%b mis=%b want 10/5/0/0", rf_link_o, rf_link_addr_o, rf_regwrite_o, misalign_o); else passed++;
    total++; if (fwd_valid_o !== 1'b1 || fwd_wa_o !== 5'd5 || fwd_data_o !== 32'h3010)
      $display("FAIL jalr_fwd: got %b/%0d/%h want 1/5/00003010", fwd_valid_o, fwd_wa_o, fwd_data_o); else passed++;
  endtask

  task automatic test_stall_flush();
    set_instr(1'b1, 1'b1, 5'd9, 32'h0000_00AA, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    stall_i = 1'b1;
    set_instr(1'b1, 1'b1, 5'd3, 32'h0000_0055, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rf_regwrite_o !== 1'b1 || rf_wa_o !== 5'd9 || rf_wd_o !== 32'hAA)
        $display("FAIL stall_hold%0d: got rw=%b wa=%0d wd=%h want 1/9/000000AA", i, rf_regwrite_o, rf_wa_o, rf_wd_o); else passed++;
    end
    stall_i = 1'b0;
    tick();
    total++; if (rf_wa_o !== 5'd3 || rf_wd_o !== 32'h55)
      $display("FAIL stall_release: got wa=%0d wd=%h want 3/00000055", rf_wa_o, rf_wd_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd9, 32'h0000_2002, 32'h0, 3'b001, 2'b00, '0, 32'h0);
    tick();
    stall_i = 1'b1;
    tick();
    tick();
    total++; if (misalign_o !== 1'b1 || rf_regwrite_o !== 1'b0)
      $display("FAIL misalign_held: got mis=%b rw=%b want 1/0", misalign_o, rf_regwrite_o); else passed++;
    flush_i = 1'b1;
    tick();
    total++; if (rf_regwrite_o !== 1'b0 || rf_wa_o !== 5'd0 || rf_wd_o !== 32'h0 || rf_link_o !== 2'b00 ||
                 rf_link_addr_o !== 5'd0 || rf_link_data_o !== 32'h0 || misalign_o !== 1'b0 || fwd_valid_o !== 1'b0)
      $display("FAIL flush_over_stall: got rw=%b wa=%0d wd=%h link=%b mis=%b fv=%b want all 0",
               rf_regwrite_o, rf_wa_o, rf_wd_o, rf_link_o, misalign_o, fwd_valid_o); else passed++;
    flush_i = 1'b0;
    stall_i = 1'b0;
    set_instr(1'b1, 1'b1, 5'd10, 32'h0000_0BBB, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    stall_i = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rf_regwrite_o !== 1'b0 || rf_wd_o !== 32'h0 || rf_wa_o !== 5'd0 || fwd_valid_o !== 1'b0)
      $display("FAIL async_reset: got rw=%b wd=%h wa=%0d fv=%b want all 0", rf_regwrite_o, rf_wd_o, rf_wa_o, fwd_valid_o); else passed++;
    stall_i = 1'b0;
    set_bubble();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    apply_reset();
    #1;
    total++; if (retire_cnt_o !== 32'd0) $display("FAIL cnt_reset: got %0d want 0", retire_cnt_o); else passed++;
    set_instr(1'b1, 1'b1, 5'd1, 32'h1, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    set_instr(1'b1, 1'b1, 5'd2, 32'h0000_0001, 32'h0, 3'b001, 2'b00, '0, 32'h0);
    tick();
    total++; if (retire_cnt_o !== 32'd1) $display("FAIL cnt_first: got %0d want 1", retire_cnt_o); else passed++;
    stall_i = 1'b1;
    set_instr(1'b1, 1'b1, 5'd3, 32'h3, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    tick();
    stall_i = 1'b0;
    tick();
    flush_i = 1'b1;
    set_instr(1'b1, 1'b1, 5'd4, 32'h4, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    flush_i = 1'b0;
    tick();
    set_instr(1'b1, 1'b1, 5'd5, 32'h5, 32'h0, 3'b000, 2'b00, '0, 32'h0);
    tick();
    set_bubble();
    tick();
    tick();
    total++; if (retire_cnt_o !== 32'd4) $display("FAIL cnt_total: got %0d want 4", retire_cnt_o); else passed++;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_bubble();
    test_reset();
    test_add();
    test_loads();
    test_misalign();
    test_link();
    test_stall_flush();
`ifdef WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
